obc_da_sequencer: RTL and testbench

OBC_DA_SEQUENCER -- requirements
Module: obc_da_sequencer

---
 rtl/obc_da_pkg.sv | 16 +
 rtl/obc_slice_mux.sv | 25 ++
 rtl/obc_da_sequencer.sv | 127 ++++++++++++
 tb/tb_obc_da_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obc_da_pkg.sv
// Shared definitions for the OBC distributed-arithmetic sequencer:
// FSM state encoding, point count and default widths.
package obc_da_pkg;

    localparam int NUM_PTS    = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ROM_W  = 32;
    localparam int DEF_ACC_W  = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/obc_slice_mux.sv
// Bit-plane extraction: picks bit 'cnt' of each captured sample to form
// the ROM address slice. The output is forced to zero when en is low.
module obc_slice_mux
    import obc_da_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 4
) (
    input  logic [NUM_PTS*DATA_W-1:0] samples,
    input  logic [CNT_W-1:0]          cnt,
    input  logic                      en,
    output logic [NUM_PTS-1:0]        slice_bits
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PTS; gi++) begin : g_bit
            logic [DATA_W-1:0] sample;
            assign sample         = samples[gi*DATA_W +: DATA_W];
            // One ROM address bit per sample: the selected bit-plane.
            assign slice_bits[gi] = en & sample[cnt];
        end
    endgenerate

endmodule

// File: rtl/obc_da_sequencer.sv
// Bit-serial OBC distributed-arithmetic sequencer. Captures a 16-sample
// block, walks its bit-planes LSB first, drives an external ROM with each
// slice and accumulates the shifted signed ROM results into one result.
// Optional feature macro: OBC_OFFSET_EN adds parameter OBC_INIT, which
// is loaded into the accumulator at accept (pre-added constant term).
module obc_da_sequencer
    import obc_da_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROM_W  = DEF_ROM_W,
    parameter int ACC_W  = DEF_ACC_W
`ifdef OBC_OFFSET_EN
    ,
    parameter logic [ACC_W-1:0] OBC_INIT = '0
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_PTS*DATA_W-1:0] in_data,
    output logic [NUM_PTS-1:0]        slice_bits,
    output logic                      slice_m,
    input  logic [ROM_W-1:0]          rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic                      busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`ifdef OBC_OFFSET_EN
    localparam logic [ACC_W-1:0] ACC_INIT = OBC_INIT;
`else
    localparam logic [ACC_W-1:0] ACC_INIT = '0;
`endif

    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg;
    logic [ACC_W-1:0]            acc_reg;
    logic [NUM_PTS*DATA_W-1:0]   samples_reg;
    logic                        accept;
    logic                        run_last;
    logic                        run_en;
    logic [ACC_W-1:0]            rom_ext;
    logic [ACC_W-1:0]            rom_shifted;

    // Sign-extend the ROM partial sum, then weight it by 2^cnt.
    assign rom_ext     = ACC_W'($signed(rom_data));
    assign rom_shifted = rom_ext << cnt_reg;

    assign run_en   = (state_reg == ST_RUN);
    assign slice_m  = run_en && (cnt_reg == CNT_LAST);
    assign out_data = acc_reg;

    obc_slice_mux #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slice_mux (
        .samples    (samples_reg),
        .cnt        (cnt_reg),
        .en         (run_en),
        .slice_bits (slice_bits)
    );

    // Next-state and handshake outputs; blocks never overlap.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        run_last   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                run_last = (cnt_reg == CNT_LAST);
                if (run_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sample capture, bit-plane counter and wrapping accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples_reg <= '0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
        end else if (accept) begin
            samples_reg <= in_data;
            cnt_reg     <= '0;
            acc_reg     <= ACC_INIT;
        end else if (run_en) begin
            acc_reg <= acc_reg + rom_shifted;
            cnt_reg <= run_last ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_obc_da_sequencer.sv
// Scoreboard bench for obc_da_sequencer. The bench supplies the ROM: either
// a constant, or an OBC-style ROM built from random coefficients (sum of the
// selected coefficients, negated on the sign plane), so each result equals
// the signed dot product of the samples with the coefficients.
module tb_obc_da_sequencer;

    localparam int DATA_W = 16;
    localparam int ROM_W  = 32;
    localparam int ACC_W  = 48;
`ifdef OBC_OFFSET_EN
    localparam longint INIT = -100;
`else
    localparam longint INIT = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid;
    logic               in_ready;
    logic [16*DATA_W-1:0] in_data;
    logic [15:0]        slice_bits;
    logic               slice_m;
    logic [ROM_W-1:0]   rom_data;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic               busy;

    always #5 clk = ~clk;

    obc_da_sequencer #(
        .DATA_W   (DATA_W),
        .ROM_W    (ROM_W),
        .ACC_W    (ACC_W)
`ifdef OBC_OFFSET_EN
        ,
        .OBC_INIT (-48'sd100)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .slice_bits (slice_bits),
        .slice_m    (slice_m),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    int          coeff [16];
    logic        rom_mode;
    logic [31:0] rom_const;
    int          ready_mode = 2;
    logic [ACC_W-1:0] exp_q [$];
    time         accept_t = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_fn(input logic [15:0] b, input logic m);
        int s;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            if (b[k]) s += coeff[k];
        end
        if (m) s = -s;
        return 32'(s);
    endfunction

    always_comb begin
        rom_data = rom_mode ? rom_const : rom_fn(slice_bits, slice_m);
    end

    // Reference: signed dot product of samples and coefficients, plus offset.
    function automatic logic [ACC_W-1:0] expect_dot(input logic [16*DATA_W-1:0] d);
        longint s;
        s = INIT;
        for (int k = 0; k < 16; k++) begin
            s += longint'(coeff[k]) * longint'($signed(d[k*16 +: 16]));
        end
        return ACC_W'(s);
    endfunction

    // Reference for a constant ROM: every plane contributes c * 2^p.
    function automatic logic [ACC_W-1:0] expect_const(input logic [31:0] c);
        longint s;
        s = longint'($signed(c)) * 65535 + INIT;
        return ACC_W'(s);
    endfunction

    function automatic logic [16*DATA_W-1:0] rand_block();
        logic [16*DATA_W-1:0] d;
        for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'($urandom);
        return d;
    endfunction

    // Consumer ready: random, forced low or forced high.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      out_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 1) out_ready = 1'b0;
            else                      out_ready = 1'b1;
        end
    end

    // Monitor: latency on each rising out_valid, scoreboard pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_valid) begin
                    check("latency", 64'(($time - 5 - accept_t) / 10), 64'(DATA_W));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: actual=0x%0h expected=none", out_data);
                    end else begin
                        check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [16*DATA_W-1:0] d, input logic [ACC_W-1:0] e);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual=in_ready 0 expected=1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        accept_t = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [16*DATA_W-1:0] d;
        logic [ACC_W-1:0]     e;
        logic [ACC_W-1:0]     held;
        logic [15:0]          eb;
        int                   n;

        in_valid  = 1'b0;
        in_data   = '0;
        rom_mode  = 1'b1;
        rom_const = 32'd0;
        for (int k = 0; k < 16; k++) coeff[k] = int'($urandom_range(0, 4095)) - 2048;

        // Reset state.
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_slice_bits", 64'(slice_bits), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        #20;
        @(posedge clk);
        #1 rst = 1'b0;

        // Constant ROM = 1 and = -1.
        ready_mode = 2;
        rom_const  = 32'd1;
        send(rand_block(), expect_const(32'd1));
        drain();
        rom_const = 32'hFFFF_FFFF;
        send(rand_block(), expect_const(32'hFFFF_FFFF));
        drain();

        // Walking-one samples: slice c holds only bit c.
        rom_mode = 1'b0;
        for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'(1) << k;
        send(d, expect_dot(d));
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            eb = 16'(1) << c;
            check($sformatf("slice_bits_c%0d", c), 64'(slice_bits), 64'(eb));
            check($sformatf("slice_m_c%0d", c), 64'(slice_m), 64'(c == 15));
        end
        @(negedge clk);
        check("done_slice_bits", 64'(slice_bits), 64'(0));
        check("done_slice_m", 64'(slice_m), 64'(0));
        drain();

        // Back-pressure in DONE.
        ready_mode = 1;
        d = rand_block();
        e = expect_dot(d);
        send(d, e);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached_done", 64'(out_valid), 64'(1));
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out_data", 64'(out_data), 64'(e));
            check("stall_stable", 64'(out_data), 64'(held));
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        ready_mode = 2;
        n = 0;
        while (!(out_valid && out_ready) && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 64'(1));
        check("post_hs_busy", 64'(busy), 64'(0));
        check("post_hs_out_valid", 64'(out_valid), 64'(0));
        drain();

        // Reset in the middle of a block (cnt = 7).
        send(rand_block(), 48'd0);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_slice_bits", 64'(slice_bits), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        d = rand_block();
        send(d, expect_dot(d));
        drain();

        // Random blocks with random consumer back-pressure.
        ready_mode = 0;
        for (int i = 0; i < 20; i++) begin
            d = rand_block();
            send(d, expect_dot(d));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
